// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider for DIV/DIVU, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to answer a zero divisor in one cycle through the ZERO state.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
`ifdef DIV_ZERO_FAST_EN
    , ZERO = 2'd3
`endif
  } state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] rem;
  logic [31:0] dvs;
  logic [31:0] dividend_raw;
  logic        sgn_q, sgn_r, div_zero;

  logic        accept;
  logic [31:0] abs_a, abs_b;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] rem_step;
  logic [31:0] q_mag, r_mag, fin_lo, fin_hi;

  assign accept = (state == IDLE) && start && !annul;
  assign abs_a  = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign abs_b  = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // Trial subtract on the upper 33 bits of the shifted remainder; the difference
  // always fits in 32 bits whenever it is kept.
  assign ge       = rem[63:31] >= {1'b0, dvs};
  assign diff     = rem[62:31] - dvs;
  assign rem_step = ge ? {diff, rem[30:0], 1'b1} : {rem[62:0], 1'b0};

  // Division by zero reports forced values, never the sign-corrected loop output.
  assign q_mag  = rem_step[31:0];
  assign r_mag  = rem_step[63:32];
  assign fin_lo = div_zero ? 32'hFFFF_FFFF : (sgn_q ? -q_mag : q_mag);
  assign fin_hi = div_zero ? dividend_raw  : (sgn_r ? -r_mag : r_mag);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (opdata2 == 32'd0) ? ZERO : BUSY;
`else
          state_next = BUSY;
`endif
        end
        BUSY:    if (cnt == 5'd31) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (state)
      BUSY: busy = 1'b1;
      DONE: begin
        busy  = 1'b1;
        ready = 1'b1;
      end
`ifdef DIV_ZERO_FAST_EN
      ZERO: begin
        busy  = 1'b1;
        ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= 5'd0;
      rem          <= 64'd0;
      dvs          <= 32'd0;
      dividend_raw <= 32'd0;
      sgn_q        <= 1'b0;
      sgn_r        <= 1'b0;
      div_zero     <= 1'b0;
    end else if (accept) begin
      cnt          <= 5'd0;
      rem          <= {32'd0, abs_a};
      dvs          <= abs_b;
      dividend_raw <= opdata1;
      sgn_q        <= signed_div && (opdata1[31] ^ opdata2[31]);
      sgn_r        <= signed_div && opdata1[31];
      div_zero     <= (opdata2 == 32'd0);
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      rem <= rem_step;
    end
  end

  // Results load on the edge entering DONE/ZERO so they are valid alongside ready;
  // an annul on that edge redirects to IDLE and leaves them untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
    end else if (state_next == DONE) begin
      result_lo <= fin_lo;
      result_hi <= fin_hi;
    end
`ifdef DIV_ZERO_FAST_EN
    else if (state_next == ZERO) begin
      result_lo <= 32'hFFFF_FFFF;
      result_hi <= opdata1;
    end
`endif
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors for div_iter; a monitor pops a scoreboard on every ready pulse.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1, opdata2;
  logic        busy, ready;
  logic [31:0] result_lo, result_hi;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          issue;
    int          lat;
  } exp_t;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .busy       (busy),
    .ready      (ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one start strobe sampled at the next rising edge; optionally records
  // the expected response and the cycle number right after that edge.
  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                       input int elat);
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.lo    = elo;
      e.hi    = ehi;
      e.issue = cyc;
      e.lat   = elat;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {31'd0, ready}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result_lo", result_lo, mon_e.lo);
        check("result_hi", result_hi, mon_e.hi);
        check("ready_latency", 32'(cyc - mon_e.issue + 1), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_lo",    result_lo,      32'd0);
    check("rst_hi",    result_hi,      32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // DIVU 100/7 with the busy window traced cycle by cycle.
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 33);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      check("busy_profile", {31'd0, busy}, (k <= 33) ? 32'd1 : 32'd0);
    end
    drain(50);

    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    drain(50);
    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 33);
    drain(50);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
    drain(50);
    issue(1'b0, 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, ZLAT);
    drain(50);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLAT);
    drain(50);

    // A second start mid-operation must be ignored.
    issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 33);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    opdata1 = 32'd7;
    opdata2 = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(50);

    // Annul mid-BUSY: no ready, previous results (10/0) held.
    issue(1'b0, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_busy", {31'd0, busy}, 32'd0);
    check("annul_lo",   result_lo,     32'd10);
    check("annul_hi",   result_hi,     32'd0);
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 33);
    drain(50);

    // Annul on the very edge that would enter DONE.
    issue(1'b0, 32'd20, 32'd4, 1'b0, 32'd0, 32'd0, 0);
    repeat (32) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_done_busy", {31'd0, busy}, 32'd0);
    check("annul_done_lo",   result_lo,     32'd3);
    check("annul_done_hi",   result_hi,     32'd0);
    repeat (3) @(negedge clk);

    // Reset mid-BUSY clears outputs at once and discards the operation.
    issue(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, busy},  32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_lo",    result_lo,      32'd0);
    check("mid_rst_hi",    result_hi,      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_lo",   result_lo,     32'd0);

    drain(50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
